// File: rtl/irq_request_latch_pkg.sv
// Shared types and sizes for the interrupt request latch.
package irq_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0] req_idx_t;

endpackage : irq_pkg

// File: rtl/irq_request_latch_prio_enc.sv
// prio_enc_4to2: combinational 4-to-2 priority encoder, bit 3 highest.
// Ports:
//   d      in   4   vector to encode
//   idx    out  2   index of highest set bit (0 when nothing set)
//   found  out  1   any bit of d set
module prio_enc_4to2
   import irq_pkg::*;
(
   input  req_vec_t d,
   output req_idx_t idx,
   output logic     found
);

   always_comb begin
      idx   = '0;
      found = |d;
      if (d[3])      idx = IDX_W'(3);
      else if (d[2]) idx = IDX_W'(2);
      else if (d[1]) idx = IDX_W'(1);
      else           idx = IDX_W'(0);
   end

endmodule : prio_enc_4to2

// File: rtl/irq_request_latch.sv
// irq_request_latch: captures request lines into a sticky pending set and
// hands out the highest-priority pending index over a valid/ready handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req_i        request lines (synchronous to clk)
//   en_i         per-line capture enable
//   out_valid    out_idx holds a granted request
//   out_ready    consumer accepts out_idx this cycle
//   out_idx      granted line index
//   pending_o    current pending vector
//   ovf_o        sticky per-line overflow flags
//   clr_ovf_i    clears ovf_o on the next edge
module irq_request_latch
   import irq_pkg::*;
#(
   parameter bit EDGE_MODE = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  req_vec_t req_i,
   input  req_vec_t en_i,
   output logic     out_valid,
   input  logic     out_ready,
   output req_idx_t out_idx,
   output req_vec_t pending_o,
   output req_vec_t ovf_o,
   input  logic     clr_ovf_i
);

   req_vec_t req_q,       req_d;
   req_vec_t pending_q,   pending_d;
   req_vec_t ovf_q,       ovf_d;
   logic     out_valid_q, out_valid_d;
   req_idx_t out_idx_q,   out_idx_d;

   req_vec_t ev;
   req_vec_t clr_vec;
   req_idx_t enc_idx;
   logic     enc_found;
   logic     out_free;
   logic     load;

   // Selection works on the registered pending set only.
   prio_enc_4to2 u_prio_enc (
      .d     (pending_q),
      .idx   (enc_idx),
      .found (enc_found)
   );

   // Capture events, load decision and next-state for all registers.
   always_comb begin
      req_d       = req_i;
      pending_d   = pending_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      clr_vec     = '0;

      ev       = en_i & (EDGE_MODE ? (req_i & ~req_q) : req_i);
      out_free = ~out_valid_q | out_ready;
      load     = out_free & enc_found;

      if (load) begin
         clr_vec     = req_vec_t'(1) << enc_idx;
         out_valid_d = 1'b1;
         out_idx_d   = enc_idx;
      end else if (out_free) begin
         // Nothing pending: drop valid, keep the last index.
         out_valid_d = 1'b0;
      end

      // Set beats clear so a same-cycle event is never lost.
      pending_d = (pending_q & ~clr_vec) | ev;

      // A new overflow beats the clear request.
      if (clr_ovf_i) ovf_d = '0;
      ovf_d = ovf_d | (ev & pending_q & ~clr_vec);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         pending_q   <= '0;
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         req_q       <= req_d;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending_o = pending_q;
   assign ovf_o     = ovf_q;

endmodule : irq_request_latch

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: edge-mode instance plus a level-mode instance.
module tb_irq_request_latch;
   import irq_pkg::*;

   logic     clk;
   logic     rst_n;

   // Edge-mode instance signals
   req_vec_t req_i, en_i, pending_o, ovf_o;
   logic     out_valid, out_ready, clr_ovf_i;
   req_idx_t out_idx;

   // Level-mode instance signals
   req_vec_t l_req, l_en, l_pending, l_ovf;
   logic     l_valid, l_ready, l_clr_ovf;
   req_idx_t l_idx;

   int n_cmp;
   int n_mis;

   irq_request_latch #(.EDGE_MODE(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .en_i      (en_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pending_o (pending_o),
      .ovf_o     (ovf_o),
      .clr_ovf_i (clr_ovf_i)
   );

   irq_request_latch #(.EDGE_MODE(1'b0)) u_lvl (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (l_req),
      .en_i      (l_en),
      .out_valid (l_valid),
      .out_ready (l_ready),
      .out_idx   (l_idx),
      .pending_o (l_pending),
      .ovf_o     (l_ovf),
      .clr_ovf_i (l_clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] pend);
      chk({tag, ".valid"}, 8'(out_valid), 8'(v));
      chk({tag, ".idx"},   8'(out_idx),   8'(idx));
      chk({tag, ".pend"},  8'(pending_o), 8'(pend));
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b0;
      req_i = '0; en_i = 4'b1111; out_ready = 1'b1; clr_ovf_i = 1'b0;
      l_req = '0; l_en = 4'b1111; l_ready = 1'b1; l_clr_ovf = 1'b0;

      // Reset state
      step();
      step();
      chk_out("rst", 1'b0, 2'd0, 4'b0000);
      chk("rst.ovf", 8'(ovf_o), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // T1 single edge
      req_i = 4'b0100;
      step();
      chk_out("t1.cap", 1'b0, 2'd0, 4'b0100);
      req_i = 4'b0000;
      step();
      chk_out("t1.grant", 1'b1, 2'd2, 4'b0000);
      step();
      chk_out("t1.idle", 1'b0, 2'd2, 4'b0000);

      // T2 priority order 3,1,0
      req_i = 4'b1011;
      step();
      chk_out("t2.cap", 1'b0, 2'd2, 4'b1011);
      req_i = 4'b0000;
      step();
      chk_out("t2.g3", 1'b1, 2'd3, 4'b0011);
      step();
      chk_out("t2.g1", 1'b1, 2'd1, 4'b0001);
      step();
      chk_out("t2.g0", 1'b1, 2'd0, 4'b0000);
      step();
      chk_out("t2.idle", 1'b0, 2'd0, 4'b0000);

      // T3 stall then drain
      out_ready = 1'b0;
      req_i = 4'b0110;
      step();
      req_i = 4'b0000;
      step();
      chk_out("t3.load", 1'b1, 2'd2, 4'b0010);
      for (int i = 0; i < 5; i++) step();
      chk_out("t3.hold", 1'b1, 2'd2, 4'b0010);
      out_ready = 1'b1;
      step();
      chk_out("t3.g1", 1'b1, 2'd1, 4'b0000);
      step();
      chk_out("t3.idle", 1'b0, 2'd1, 4'b0000);

      // T4 overflow, sticky, clear, set-wins
      out_ready = 1'b0;
      req_i = 4'b1000;
      step();
      req_i = 4'b0000;
      step();
      chk_out("t4.busy", 1'b1, 2'd3, 4'b0000);
      req_i = 4'b0010;
      step();
      chk("t4.pend1", 8'(pending_o), 8'h02);
      chk("t4.noovf", 8'(ovf_o), 8'h00);
      req_i = 4'b0000;
      step();
      req_i = 4'b0010;
      step();
      chk("t4.ovf", 8'(ovf_o), 8'h02);
      req_i = 4'b0000;
      step();
      chk("t4.sticky", 8'(ovf_o), 8'h02);
      clr_ovf_i = 1'b1;
      step();
      clr_ovf_i = 1'b0;
      chk("t4.clr", 8'(ovf_o), 8'h00);
      out_ready = 1'b1;
      req_i = 4'b0010;
      step();
      chk_out("t4.setwins", 1'b1, 2'd1, 4'b0010);
      chk("t4.setwins.ovf", 8'(ovf_o), 8'h00);
      req_i = 4'b0000;
      step();
      chk_out("t4.regrant", 1'b1, 2'd1, 4'b0000);
      step();
      chk_out("t4.idle", 1'b0, 2'd1, 4'b0000);

      // T5 enable mask
      en_i = 4'b1110;
      req_i = 4'b0001;
      step();
      chk("t5.mask.pend", 8'(pending_o), 8'h00);
      req_i = 4'b0000;
      step();
      chk("t5.mask.valid", 8'(out_valid), 8'h00);
      en_i = 4'b1111;

      // T5 level mode: held line re-granted each accept
      l_req = 4'b1000;
      step();
      chk("t5.lvl.pend", 8'(l_pending), 8'h08);
      step();
      chk("t5.lvl.v1", 8'(l_valid), 8'h01);
      chk("t5.lvl.i1", 8'(l_idx), 8'h03);
      chk("t5.lvl.p1", 8'(l_pending), 8'h08);
      step();
      chk("t5.lvl.v2", 8'(l_valid), 8'h01);
      chk("t5.lvl.i2", 8'(l_idx), 8'h03);
      l_req = 4'b0000;
      step();
      chk("t5.lvl.v3", 8'(l_valid), 8'h01);
      chk("t5.lvl.p3", 8'(l_pending), 8'h00);
      step();
      chk("t5.lvl.idle", 8'(l_valid), 8'h00);
      chk("t5.lvl.ovf", 8'(l_ovf), 8'h00);

      // T6 reset mid-handshake, line held through release
      out_ready = 1'b0;
      req_i = 4'b0100;
      step();
      req_i = 4'b0000;
      step();
      chk_out("t6.pre", 1'b1, 2'd2, 4'b0000);
      #2;
      rst_n = 1'b0;
      req_i = 4'b0001;
      #1;
      chk_out("t6.async", 1'b0, 2'd0, 4'b0000);
      chk("t6.ovf", 8'(ovf_o), 8'h00);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk_out("t6.cap", 1'b0, 2'd0, 4'b0001);
      step();
      chk_out("t6.grant", 1'b1, 2'd0, 4'b0000);
      step();
      chk_out("t6.once", 1'b0, 2'd0, 4'b0000);
      step();
      chk_out("t6.still", 1'b0, 2'd0, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_irq_request_latch
